// File: rtl/board_tile_mapper.sv
// board_tile_mapper: maps the VGA pixel coordinate onto the 4x4 tile board.
// It drives the tile-sprite ROM address two cycles after the coordinate, and
// a pixel-class tag three cycles after it, so the tag lines up with ROM data.
// The game logic writes into a pending board register. That value is copied
// into a shadow board at frame start, so one frame never shows two boards.
module board_tile_mapper #(
  parameter int unsigned X0   = 152,
  parameter int unsigned Y0   = 72,
  parameter int unsigned GAP  = 16,
  parameter int unsigned TILE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  col_addr,
  input  logic [8:0]  row_addr,
  input  logic        board_we,
  input  logic [63:0] board_wdata,
  output logic [11:0] addr,
  output logic [1:0]  pix_class,
  output logic        frame_swap
);

  localparam int unsigned PITCH = TILE + GAP;
  localparam int unsigned SPAN  = 4 * PITCH + GAP;

  int unsigned col_u;
  int unsigned row_u;

  // Decoded values for the current input coordinate; stage-1 next state.
  logic       hit_x_d, hit_y_d;
  logic       in_x_d, in_y_d;
  logic [1:0] tc_d, tr_d;
  logic [3:0] lx4_d, ly4_d;
  logic       s1_board_d, s1_tile_d;

  // Stage 1 registers.
  logic       s1_board_q, s1_tile_q;
  logic [3:0] s1_idx_q, s1_lx_q, s1_ly_q;

  // Stage 2 / stage 3 registers.
  logic [11:0] addr_d, addr_q;
  logic [1:0]  s2_cls_d, s2_cls_q;
  logic [1:0]  pix_q;

  // Board update path.
  logic [63:0] pend_d, pend_q;
  logic        pflag_d, pflag_q;
  logic [63:0] shadow_d, shadow_q;
  logic        swap_d, swap_q;
  logic        frame_start;

  assign col_u = 32'(col_addr);
  assign row_u = 32'(row_addr);
  assign frame_start = (col_addr == '0) && (row_addr == '0);

  // Horizontal decode: find the tile column with constant range compares.
  always_comb begin
    hit_x_d = 1'b0;
    tc_d    = '0;
    lx4_d   = '0;
    in_x_d  = (col_u >= X0) && (col_u < X0 + SPAN);
    for (int unsigned c = 0; c < 4; c++) begin
      if ((col_u >= X0 + GAP + c * PITCH) && (col_u < X0 + GAP + c * PITCH + TILE)) begin
        hit_x_d = 1'b1;
        tc_d    = 2'(c);
        lx4_d   = 4'((col_u - (X0 + GAP + c * PITCH)) >> 2);
      end
    end
  end

  // Vertical decode: the same scheme applied to the row.
  always_comb begin
    hit_y_d = 1'b0;
    tr_d    = '0;
    ly4_d   = '0;
    in_y_d  = (row_u >= Y0) && (row_u < Y0 + SPAN);
    for (int unsigned r = 0; r < 4; r++) begin
      if ((row_u >= Y0 + GAP + r * PITCH) && (row_u < Y0 + GAP + r * PITCH + TILE)) begin
        hit_y_d = 1'b1;
        tr_d    = 2'(r);
        ly4_d   = 4'((row_u - (Y0 + GAP + r * PITCH)) >> 2);
      end
    end
  end

  assign s1_board_d = in_x_d && in_y_d;
  assign s1_tile_d  = hit_x_d && hit_y_d;

  // Stage 1: register classification, tile index and scaled sprite offsets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_board_q <= 1'b0;
      s1_tile_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_lx_q    <= '0;
      s1_ly_q    <= '0;
    end else begin
      s1_board_q <= s1_board_d;
      s1_tile_q  <= s1_tile_d;
      s1_idx_q   <= {tr_d, tc_d};
      s1_lx_q    <= lx4_d;
      s1_ly_q    <= ly4_d;
    end
  end

  // Stage 2 next state: ROM address from the shadow exponent, and the class tag.
  always_comb begin
    addr_d   = '0;
    s2_cls_d = 2'b00;
    if (s1_tile_q) begin
      addr_d   = {shadow_q[{s1_idx_q, 2'b00} +: 4], s1_ly_q, s1_lx_q};
      s2_cls_d = 2'b10;
    end else if (s1_board_q) begin
      s2_cls_d = 2'b01;
    end
  end

  // Stage 2 and 3: the address leaves after stage 2, the tag one cycle later for the ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      s2_cls_q <= 2'b00;
      pix_q    <= 2'b00;
    end else begin
      addr_q   <= addr_d;
      s2_cls_q <= s2_cls_d;
      pix_q    <= s2_cls_q;
    end
  end

  // Board update: a swap copies the old pending value, even when a write lands in the same cycle.
  always_comb begin
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    shadow_d = shadow_q;
    swap_d   = 1'b0;
    if (frame_start && pflag_q) begin
      shadow_d = pend_q;
      pflag_d  = 1'b0;
      swap_d   = 1'b1;
    end
    if (board_we) begin
      pend_d  = board_wdata;
      pflag_d = 1'b1;
    end
  end

  // Board update registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      shadow_q <= '0;
      swap_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      shadow_q <= shadow_d;
      swap_q   <= swap_d;
    end
  end

  assign addr       = addr_q;
  assign pix_class  = pix_q;
  assign frame_swap = swap_q;

endmodule

// File: tb/tb_board_tile_mapper.sv
// Testbench for board_tile_mapper: directed and random stimulus checked every cycle against a geometric reference model.
module tb_board_tile_mapper;

  localparam int X0 = 152;
  localparam int Y0 = 72;
  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  col_addr = '0;
  logic [8:0]  row_addr = '0;
  logic        board_we = 1'b0;
  logic [63:0] board_wdata = '0;
  logic [11:0] addr;
  logic [1:0]  pix_class;
  logic        frame_swap;

  board_tile_mapper #(.X0(152), .Y0(72), .GAP(16), .TILE(64)) dut (
    .clk(clk), .rst(rst), .col_addr(col_addr), .row_addr(row_addr),
    .board_we(board_we), .board_wdata(board_wdata),
    .addr(addr), .pix_class(pix_class), .frame_swap(frame_swap)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [63:0] m_pend, m_shadow;
  logic        m_flag;
  int h1_cls, h1_idx, h1_lx, h1_ly, h2_cls;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Geometry from first principles: board origin, pitch 80, tile 64.
  function automatic void classify(input int col, input int row, output int cls,
                                   output int idx, output int lx4, output int ly4);
    int rx, ry;
    rx = col - X0;
    ry = row - Y0;
    cls = 0; idx = 0; lx4 = 0; ly4 = 0;
    if (rx >= 0 && rx < 336 && ry >= 0 && ry < 336) begin
      cls = 1;
      if (rx >= GAP && ry >= GAP && (rx - GAP) % 80 < 64 && (ry - GAP) % 80 < 64) begin
        cls = 2;
        idx = 4 * ((ry - GAP) / 80) + (rx - GAP) / 80;
        lx4 = ((rx - GAP) % 80) / 4;
        ly4 = ((ry - GAP) % 80) / 4;
      end
    end
  endfunction

  task automatic model_clear();
    m_pend = '0; m_shadow = '0; m_flag = 1'b0;
    h1_cls = 0; h1_idx = 0; h1_lx = 0; h1_ly = 0; h2_cls = 0;
  endtask

  // One clock: apply inputs, advance model, compare all outputs.
  task automatic step(input int col, input int row, input logic we, input logic [63:0] wd);
    logic [11:0] e_addr;
    logic [3:0]  nib;
    logic        e_swap;
    int          e_pix;
    col_addr = 10'(col); row_addr = 9'(row); board_we = we; board_wdata = wd;
    @(posedge clk); #1;
    nib = m_shadow[h1_idx * 4 +: 4];
    e_addr = (h1_cls == 2) ? {nib, 4'(h1_ly), 4'(h1_lx)} : 12'h000;
    e_pix  = h2_cls;
    e_swap = (col == 0 && row == 0) && m_flag;
    if (e_swap) begin
      m_shadow = m_pend;
      m_flag = 1'b0;
    end
    if (we) begin
      m_pend = wd;
      m_flag = 1'b1;
    end
    h2_cls = h1_cls;
    classify(col, row, h1_cls, h1_idx, h1_lx, h1_ly);
    check_eq("addr", 32'(addr), 32'(e_addr));
    check_eq("pix_class", 32'(pix_class), 32'(e_pix));
    check_eq("frame_swap", 32'(frame_swap), 32'(e_swap));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(100, 100, 1'b0, '0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check_eq("rst_addr", 32'(addr), 32'h0);
    check_eq("rst_pix", 32'(pix_class), 32'h0);
    check_eq("rst_swap", 32'(frame_swap), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Probe the first pixel of tile 0 and return the address seen two cycles later.
  task automatic probe_tile0(output logic [11:0] a);
    step(X0 + GAP, Y0 + GAP, 1'b0, '0);
    step(100, 100, 1'b0, '0);
    a = addr;
  endtask

  initial begin
    logic [11:0] a;
    int swaps, n_tile, n_hi;
    int col, row;
    logic we;
    logic [63:0] wd;

    #2;
    do_reset();

    // Outside the board after reset.
    step(100, 100, 1'b0, '0);
    step(100, 100, 1'b0, '0);
    check_eq("dir_addr_outside", 32'(addr), 32'h0);
    step(100, 100, 1'b0, '0);
    check_eq("dir_pix_outside", 32'(pix_class), 32'h0);

    // Load exponent 0xB into tile 5 and swap.
    step(100, 100, 1'b1, 64'h0000_0000_00B0_0000);
    step(0, 0, 1'b0, '0);
    check_eq("dir_swap1", 32'(frame_swap), 32'h1);
    step(256, 180, 1'b0, '0);
    step(100, 100, 1'b0, '0);
    check_eq("dir_addr_b32", 32'(addr), 32'hB32);
    step(100, 100, 1'b0, '0);
    check_eq("dir_pix_tile", 32'(pix_class), 32'h2);

    // Corner gap, then just past the board.
    step(152, 72, 1'b0, '0);
    step(100, 100, 1'b0, '0);
    check_eq("dir_addr_gap", 32'(addr), 32'h0);
    step(100, 100, 1'b0, '0);
    check_eq("dir_pix_gap", 32'(pix_class), 32'h1);
    step(488, 408, 1'b0, '0);
    idle(2);
    check_eq("dir_pix_past", 32'(pix_class), 32'h0);

    // Two writes before a frame start: last one wins, one pulse only.
    step(100, 100, 1'b1, 64'h1111_1111_1111_1111);
    step(100, 100, 1'b1, 64'h2222_2222_2222_2222);
    swaps = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1'b0, '0);
      if (frame_swap) swaps++;
    end
    check_eq("dir_one_pulse", 32'(swaps), 32'd1);
    probe_tile0(a);
    check_eq("dir_last_wins", 32'(a), 32'h200);

    // Write on the frame-start cycle: old pending swaps now, new one next frame.
    step(100, 100, 1'b1, 64'h3333_3333_3333_3333);
    step(0, 0, 1'b1, 64'h4444_4444_4444_4444);
    check_eq("dir_same_cycle_swap", 32'(frame_swap), 32'h1);
    probe_tile0(a);
    check_eq("dir_same_cycle_old", 32'(a), 32'h300);
    step(0, 0, 1'b0, '0);
    check_eq("dir_deferred_swap", 32'(frame_swap), 32'h1);
    probe_tile0(a);
    check_eq("dir_deferred_new", 32'(a), 32'h400);
    step(0, 0, 1'b0, '0);
    check_eq("dir_no_pending", 32'(frame_swap), 32'h0);

    // Randomized traffic, biased toward the board area.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        col = 0; row = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        col = $urandom_range(140, 500); row = $urandom_range(60, 420);
      end else begin
        col = $urandom_range(0, 639); row = $urandom_range(0, 479);
      end
      we = ($urandom_range(0, 9) == 0);
      wd = {$urandom, $urandom};
      step(col, row, we, wd);
    end

    // Mid-frame reset with data pending: nothing swaps afterwards.
    step(100, 100, 1'b1, 64'hFEDC_BA98_7654_3210);
    step(300, 200, 1'b0, '0);
    do_reset();
    step(0, 0, 1'b0, '0);
    check_eq("dir_rst_no_swap", 32'(frame_swap), 32'h0);
    probe_tile0(a);
    check_eq("dir_rst_shadow_empty", 32'(a), 32'h000);

    // Board sweep (every other row) with an all-0x1 board.
    step(100, 100, 1'b1, 64'h1111_1111_1111_1111);
    step(0, 0, 1'b0, '0);
    n_tile = 0; n_hi = 0;
    for (int r = Y0; r < Y0 + 336; r += 2) begin
      for (int c = X0; c < X0 + 336; c++) begin
        step(c, r, 1'b0, '0);
        if (pix_class == 2'b10) n_tile++;
        if (addr[11:8] == 4'h1) n_hi++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(100, 100, 1'b0, '0);
      if (pix_class == 2'b10) n_tile++;
      if (addr[11:8] == 4'h1) n_hi++;
    end
    check_eq("sweep_tile_count", 32'(n_tile), 32'd32768);
    check_eq("sweep_exp1_count", 32'(n_hi), 32'd32768);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #5000000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1);
  end

endmodule

// File: doc/board_tile_mapper.md
Name: board_tile_mapper

Overview:
- Converts the VGA controller's current pixel coordinate into a tile-sprite ROM address for the 4x4 2048 board.
- Sits directly upstream of the tile ROM. It consumes col_addr/row_addr from the VGA controller and drives the ROM address.
- Also emits a pixel-class tag, delayed to line up with the ROM output, so the colour stage can choose sprite data, gap colour or background.
- Holds a tear-free shadow copy of the board. The game logic writes a new board at any time; the shadow updates only at frame start.

Parameters:
- X0, 152, left pixel column of board area (board is 336 px wide).
- Y0, 72, top pixel row of board area (board is 336 px high).
- GAP, 16, gap width in pixels, at board edges and between tiles.
- TILE, 64, tile edge in pixels. Fixed at 64: sprite is 16x16, scaled x4.

Ports:
- clk  in  1  pixel clock, same as the VGA controller clock.
- rst  in  1  asynchronous reset, active-high.
- col_addr  in  10  current pixel column, 0..639.
- row_addr  in  9  current pixel row, 0..479.
- board_we  in  1  one-cycle strobe that loads a new board.
- board_wdata  in  64  16 nibbles. Nibble i = bits[4i+3:4i] = exponent of tile i (row-major, i = 4*row + col). 0 = empty.
- addr  out  12  tile ROM address.
- pix_class  out  2  00 outside board, 01 gap/frame, 10 tile pixel. Aligned with ROM douta.
- frame_swap  out  1  one-cycle pulse when the shadow board is updated.

Behaviour:
- Reset (async, rst=1): addr=0, pix_class=00, frame_swap=0. Pending register, pending flag, shadow board and all pipeline registers are 0.
- Pitch P = TILE + GAP = 80. Board spans X0..X0+335 and Y0..Y0+335.
- Tile column c (0..3) occupies X0+GAP+80c .. X0+GAP+80c+63. Tile rows use the same formula with Y0.
- Tile index and local offsets come from constant range compares, with no divider:
  - lx = col - tile_x_start (6 bits); ly likewise.
- Stage 1 (registered on clk), from the input coordinate:
  - in_board = coordinate inside the 336x336 board.
  - in_tile = inside a tile in both axes.
  - tile_idx (4b), lx[5:2], ly[5:2].
- Stage 2 (registered):
  - addr = {shadow[tile_idx] (4b), ly[5:2], lx[5:2]}.
  - When in_tile=0, addr = 0.
- Latency: addr is valid 2 cycles after the corresponding col/row input.
- pix_class is the stage-1 classification delayed to 3 cycles after input, matching the 1-cycle ROM read.
  - 10 when in_tile.
  - 01 when in_board and not in_tile.
  - 00 otherwise.
- Exponents 12..15 map directly. No clamping.
- Board update:
  - board_we=1: pending <= board_wdata, pending_flag <= 1. A later write before the swap overwrites pending (last write wins).
  - Frame start = cycle where col_addr==0 and row_addr==0 on the input.
  - At frame start with pending_flag=1: shadow <= pending, pending_flag <= 0, frame_swap=1 on the next cycle.
  - If (0,0) persists on the input for several cycles, only the first cycle swaps. The flag is already clear on later cycles.
  - board_we on the same cycle as frame start: the shadow takes the old pending value. The new data goes into pending and pending_flag stays 1, so it swaps at the next frame.
  - Frame start with pending_flag=0: no change and no frame_swap.
- The shadow is read in stage 2. The first pixels of a new frame, still in the pipeline, already see the new shadow. This is acceptable: (0,0) is outside the board.
- Reset mid-frame: pipeline outputs return to 0 immediately, pending data is lost, and the shadow is all-empty.

Test Plan:
- Reset, then drive (col,row)=(100,100) → after 2 cycles addr=0; after 3 cycles pix_class=00.
- board_we with nibble 5 = 0xB (tile row1, col1), then input (0,0) → frame_swap=1 one cycle later.
  - Then (col,row)=(152+16+80+8, 72+16+80+12)=(256,180): lx=8, ly=12.
  - Required: addr=0xB32 at cycle+2, pix_class=10 at cycle+3.
- Input (152,72), the corner gap → pix_class=01, addr=0. Input (488,408), just past the board → pix_class=00.
- Write board A, write board B, then frame start → shadow=B, exactly one frame_swap pulse.
- board_we(C) on the same cycle as frame start with pending=B → shadow=B and frame_swap; C swaps on the following (0,0).
- Sweep a full 640x480 frame with an all-0x1 board → every tile-class pixel has addr[11:8]=1. Count of pix_class=10 equals 16*64*64=65536.
